ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Round-robin arbiter and sequencer that shares one single-port `ram` instance between four requesters, such as the NBin/SB/NBout buffer fill and drain engines. Each cycle it grants at most one request and drives the RAM's address, data, `we` and `oe` pins. It produces the 2-bit select for the `mux_4_to_1` steering the granted requester's fields, and returns registered read data tagged to the requester that issued the read. It enforces the RAM's read-to-write turnaround.

## Interface
Parameters:
- `DATA_WIDTH`, 8, RAM word width.
- `ADDR_WIDTH`, 8, RAM address width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req`  in  4  per-requester request. Once raised, it is held with `i_we`/`i_addr`/`i_wdata` stable until the matching `o_gnt` is seen.
- `i_we`  in  4  per-requester op type: 1 = write, 0 = read.
- `i_addr`  in  4*ADDR_WIDTH  requester k occupies bits [(k+1)*ADDR_WIDTH-1 : k*ADDR_WIDTH].
- `i_wdata`  in  4*DATA_WIDTH  same packing as `i_addr`.
- `o_gnt`  out  4  one-hot or zero, combinational; the request is accepted in the cycle `o_gnt[k]`=1.
- `o_sel`  out  2  index of the granted requester; holds the last granted index when idle.
- `o_ram_addr`  out  ADDR_WIDTH  `i_addr` slice selected by `o_sel`.
- `o_ram_data`  out  DATA_WIDTH  `i_wdata` slice selected by `o_sel`.
- `o_ram_we`  out  1  1 only in a cycle granting a write.
- `o_ram_oe`  out  1  always equal to !`o_ram_we`.
- `i_ram_rdata`  in  DATA_WIDTH  RAM `o_data`.
- `o_rvalid`  out  4  one-hot or zero; single-cycle read-return strobe.
- `o_rdata`  out  DATA_WIDTH  registered read data; holds until the next return.

## Operation
- State:
  - `ptr` (2 bits): the highest-priority requester.
  - `last_sel` (2 bits).
  - `rd1_v`/`rd1_tag`: a read was granted in the previous cycle.
  - `rd2_v`/`rd2_tag`: the return stage.
  - `o_rdata` register.
- Eligibility: requester k is eligible if `i_req[k]`=1 and not (`rd1_v`=1 and `i_we[k]`=1). Writes are therefore blocked in the cycle immediately after a read grant, because the RAM tri-states `o_data` whenever `we`=1.
- Arbitration: scan eligible requesters in order `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4). The first one found is granted.
- On a grant to k:
  - `ptr` <= k+1 (mod 4, so 3 wraps to 0).
  - `last_sel` <= k.
- With no eligible requester: `o_gnt`=0; `ptr` and `last_sel` are unchanged; `o_ram_we`=0.
- `o_sel` = granted index when a grant exists, else `last_sel`.
- Read grant to k in cycle t:
  - `rd1_v` <= 1 and `rd1_tag` <= k at the end of t.
  - In t+1, `o_ram_we` is guaranteed 0, so `i_ram_rdata` is valid. At the end of t+1, `o_rdata` <= `i_ram_rdata`, `rd2_v` <= 1 and `rd2_tag` <= `rd1_tag`.
  - `o_rvalid` = `rd2_v` ? onehot(`rd2_tag`) : 0.
- Write grant: the RAM samples `o_ram_addr`/`o_ram_data` with `we`=1 at the end of t. There is no return strobe.
- Arithmetic: only the mod-4 `ptr` increment; no other width rules.

## Timing
- Grant latency: 0 cycles; `o_gnt` is combinational from `i_req`/`i_we`/state.
- Read latency: grant in t, `o_rvalid`/`o_rdata` in t+2. Back-to-back reads give one return per cycle.
- Read followed by a write request: the write is granted no earlier than t+2 (one bubble). Another requester's pending read may be granted in t+1 instead.
- Write followed by a read: no bubble.
- Same-cycle requests: only one grant; the loser keeps `i_req` high and is served under the rotated priority.
- Reset:
  - Values after the reset edge: `ptr`=0, `last_sel`=0, `rd1_v`=`rd2_v`=0, `o_rdata`=0.
  - Outputs after reset: `o_rvalid`=0, `o_sel`=0.
  - While `reset`=1: `o_gnt`=0, `o_ram_we`=0, `o_ram_oe`=1.
- Reset mid-read: a read granted in the cycle before reset, or in the reset cycle, produces no `o_rvalid`.

## Test plan
- Reset, then `i_req`=4'b0000 -> `o_gnt`=0, `o_ram_we`=0, `o_ram_oe`=1, `o_sel`=0, `o_rvalid`=0, `o_rdata`=0.
- Requester 2 writes 8'hA5 to addr 8'h10, then reads 8'h10 -> write granted in cycle 0 with `o_ram_we`=1; read granted in cycle 1; `o_rvalid`=4'b0100 and `o_rdata`=8'hA5 in cycle 3.
- All four requesters hold read requests from reset -> grants 0,1,2,3,0 on consecutive cycles; `o_rvalid` follows the same order two cycles later.
- Requester 0 reads at cycle t while requester 1 holds a write -> `o_gnt`=0 at t+1 (bubble); requester 1 granted at t+2; `i_ram_rdata` not tri-stated at t+1.
- `ptr`=3 with requesters 0 and 3 both requesting -> requester 3 granted first, `ptr` wraps to 0, requester 0 granted next.
- Read granted to requester 1, then `reset` asserted the next cycle -> `o_rvalid` stays 0 and `o_rdata` returns to 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port RAM between four requesters using a rotating
// (round-robin) priority. At most one request is granted per cycle; the
// granted requester's address/data/op drive the RAM pins directly, and reads
// come back two cycles later as a registered word with a one-hot strobe that
// names the requester that issued the read.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   i_req/i_we               per-requester request and op (1 = write)
//   i_addr/i_wdata           packed per-requester address / write data
//   o_gnt                    one-hot grant (combinational), zero when idle
//   o_sel                    granted index, or last granted index when idle
//   o_ram_addr/o_ram_data    fields of the selected requester
//   o_ram_we/o_ram_oe        RAM write enable and its complement
//   i_ram_rdata              RAM read data (valid the cycle after a read grant)
//   o_rvalid/o_rdata         read-return strobe (one-hot) and registered data
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              i_req,
  input  logic [3:0]              i_we,
  input  logic [4*ADDR_WIDTH-1:0] i_addr,
  input  logic [4*DATA_WIDTH-1:0] i_wdata,
  output logic [3:0]              o_gnt,
  output logic [1:0]              o_sel,
  output logic [ADDR_WIDTH-1:0]   o_ram_addr,
  output logic [DATA_WIDTH-1:0]   o_ram_data,
  output logic                    o_ram_we,
  output logic                    o_ram_oe,
  input  logic [DATA_WIDTH-1:0]   i_ram_rdata,
  output logic [3:0]              o_rvalid,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  logic [1:0]            ptr_reg;
  logic [1:0]            last_sel_reg;
  logic                  rd1_v_reg;
  logic [1:0]            rd1_tag_reg;
  logic                  rd2_v_reg;
  logic [1:0]            rd2_tag_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;

  logic [3:0]            eligible;
  logic [ADDR_WIDTH-1:0] addr_slice [4];
  logic [DATA_WIDTH-1:0] wdata_slice [4];

  logic                  gnt_found;
  logic [1:0]            gnt_idx;
  logic [1:0]            cand;
  logic [1:0]            sel;

  // A write cannot be granted the cycle after a read grant: the RAM drives
  // its read data during that cycle and would tri-state it if we=1.
  // Nothing is eligible while reset is held.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_req
      assign eligible[gi]    = !reset && i_req[gi] && !(rd1_v_reg && i_we[gi]);
      assign addr_slice[gi]  = i_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_slice[gi] = i_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Scan from ptr upward (mod 4); the first eligible requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_reg;
    cand      = ptr_reg;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_reg + i[1:0];
      if (!gnt_found && eligible[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign sel        = gnt_found ? gnt_idx : last_sel_reg;
  assign o_sel      = sel;
  assign o_gnt      = gnt_found ? (4'b0001 << gnt_idx) : 4'b0000;
  assign o_ram_addr = addr_slice[sel];
  assign o_ram_data = wdata_slice[sel];
  assign o_ram_we   = gnt_found && i_we[gnt_idx];
  assign o_ram_oe   = !o_ram_we;
  assign o_rvalid   = rd2_v_reg ? (4'b0001 << rd2_tag_reg) : 4'b0000;
  assign o_rdata    = rdata_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg      <= 2'd0;
      last_sel_reg <= 2'd0;
      rd1_v_reg    <= 1'b0;
      rd1_tag_reg  <= 2'd0;
      rd2_v_reg    <= 1'b0;
      rd2_tag_reg  <= 2'd0;
      rdata_reg    <= '0;
    end else begin
      if (gnt_found) begin
        ptr_reg      <= gnt_idx + 2'd1;  // natural wrap 3 -> 0
        last_sel_reg <= gnt_idx;
      end
      // Stage 1: read issued to the RAM this cycle.
      rd1_v_reg   <= gnt_found && !i_we[gnt_idx];
      rd1_tag_reg <= gnt_idx;
      // Stage 2: RAM data is valid now; capture it and raise the strobe.
      rd2_v_reg   <= rd1_v_reg;
      rd2_tag_reg <= rd1_tag_reg;
      if (rd1_v_reg) begin
        rdata_reg <= i_ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  i_req;
  logic [3:0]  i_we;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  o_gnt;
  logic [1:0]  o_sel;
  logic [7:0]  o_ram_addr;
  logic [7:0]  o_ram_data;
  logic        o_ram_we;
  logic        o_ram_oe;
  logic [7:0]  i_ram_rdata;
  logic [3:0]  o_rvalid;
  logic [7:0]  o_rdata;

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_gnt(o_gnt), .o_sel(o_sel), .o_ram_addr(o_ram_addr),
    .o_ram_data(o_ram_data), .o_ram_we(o_ram_we), .o_ram_oe(o_ram_oe),
    .i_ram_rdata(i_ram_rdata), .o_rvalid(o_rvalid), .o_rdata(o_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read; drives 0 instead of
  // valid data in a write cycle (stands in for the tri-stated bus).
  logic [7:0] ram [256];
  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    i_ram_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (o_ram_we) ram[o_ram_addr] <= o_ram_data;
    i_ram_rdata <= o_ram_we ? 8'h00 : ram[o_ram_addr];
  end

  // Reference model state
  typedef struct { int due; int tag; logic [7:0] data; } ret_t;
  ret_t       ret_q [$];
  int         m_ptr, m_last, cyc;
  bit         m_rd_prev;
  logic [7:0] m_rdata;
  logic [7:0] mem_m [256];

  int tests, fails;
  logic [3:0] obs_gnt, obs_rvalid;
  logic [1:0] obs_sel;
  logic       obs_we, obs_oe;
  logic [7:0] obs_rdata;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive, compare against the model mid-cycle, advance.
  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    bit         found;
    int         k;
    logic [3:0] erv;
    logic [7:0] erd;
    bit         pop;
    reset = rst; i_req = req; i_we = we; i_addr = addr; i_wdata = wdata;
    @(negedge clk);
    obs_gnt = o_gnt; obs_sel = o_sel; obs_we = o_ram_we; obs_oe = o_ram_oe;
    obs_rvalid = o_rvalid; obs_rdata = o_rdata;
    found = 0; k = 0;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        int c;
        c = (m_ptr + i) % 4;
        if (!found && req[c] && !(m_rd_prev && we[c])) begin
          found = 1; k = c;
        end
      end
    end
    pop = (ret_q.size() > 0) && (ret_q[0].due == cyc);
    erv = pop ? 4'(1 << ret_q[0].tag) : 4'b0000;
    erd = pop ? ret_q[0].data : m_rdata;
    check("gnt", obs_gnt, found ? (1 << k) : 0);
    check("ram_we", obs_we, found && we[k]);
    check("ram_oe", obs_oe, !(found && we[k]));
    if (!rst) begin
      check("sel", obs_sel, found ? k : m_last);
      check("rvalid", obs_rvalid, erv);
      check("rdata", obs_rdata, erd);
    end
    if (found) begin
      check("ram_addr", o_ram_addr, addr[k*8 +: 8]);
      if (we[k]) check("ram_data", o_ram_data, wdata[k*8 +: 8]);
    end
    // model update for the coming clock edge
    if (pop) begin
      m_rdata = ret_q[0].data;
      void'(ret_q.pop_front());
    end
    if (rst) begin
      m_ptr = 0; m_last = 0; m_rd_prev = 0; m_rdata = 8'h00;
      ret_q.delete();
    end else begin
      m_rd_prev = found && !we[k];
      if (found) begin
        m_ptr = (k + 1) % 4;
        m_last = k;
        if (we[k]) mem_m[addr[k*8 +: 8]] = wdata[k*8 +: 8];
        else ret_q.push_back('{cyc + 2, k, mem_m[addr[k*8 +: 8]]});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct { logic [3:0] req; logic [3:0] exp_gnt; logic [1:0] exp_sel; } vec_t;
  vec_t vecs [10];

  logic        p_v [4];
  logic        p_we [4];
  logic [7:0]  p_addr [4];
  logic [7:0]  p_data [4];

  initial begin
    logic [31:0] a, d;
    logic [3:0]  rq, wq;
    tests = 0; fails = 0; cyc = 0;
    m_ptr = 0; m_last = 0; m_rd_prev = 0; m_rdata = 0;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;

    // Reset, then idle
    step(1, 4'h0, 4'h0, 32'h0, 32'h0);
    step(1, 4'hF, 4'hF, 32'h0, 32'h0);
    step(0, 4'h0, 4'h0, 32'h0, 32'h0);
    check("rst_gnt", obs_gnt, 0);
    check("rst_we", obs_we, 0);
    check("rst_oe", obs_oe, 1);
    check("rst_sel", obs_sel, 0);
    check("rst_rvalid", obs_rvalid, 0);
    check("rst_rdata", obs_rdata, 0);

    // Requester 2: write A5 to 0x10, then read 0x10
    step(0, 4'b0100, 4'b0100, 32'h0010_0000, 32'h00A5_0000);
    check("wr2_gnt", obs_gnt, 4'b0100);
    check("wr2_we", obs_we, 1);
    step(0, 4'b0100, 4'b0000, 32'h0010_0000, 32'h0);
    check("rd2_gnt", obs_gnt, 4'b0100);
    step(0, 4'h0, 4'h0, 32'h0, 32'h0);
    step(0, 4'h0, 4'h0, 32'h0, 32'h0);
    check("rd2_rvalid", obs_rvalid, 4'b0100);
    check("rd2_rdata", obs_rdata, 8'hA5);

    // Read (req 0) then write (req 1): one bubble. ptr is 3 here.
    step(0, 4'b0011, 4'b0010, 32'h0000_0510, 32'h0000_3300);
    check("rw_rd_gnt", obs_gnt, 4'b0001);
    step(0, 4'b0010, 4'b0010, 32'h0000_0510, 32'h0000_3300);
    check("rw_bubble_gnt", obs_gnt, 4'b0000);
    check("rw_bubble_we", obs_we, 0);
    step(0, 4'b0010, 4'b0010, 32'h0000_0510, 32'h0000_3300);
    check("rw_wr_gnt", obs_gnt, 4'b0010);
    step(0, 4'h0, 4'h0, 32'h0, 32'h0);

    // ptr = 3 with requesters 0 and 3 (writes): 3 first, then wrap to 0
    step(0, 4'b0100, 4'b0100, 32'h0020_0000, 32'h0011_0000);
    step(0, 4'b1001, 4'b1001, 32'h3000_0031, 32'h7700_0066);
    check("wrap_first", obs_gnt, 4'b1000);
    step(0, 4'b0001, 4'b0001, 32'h3000_0031, 32'h7700_0066);
    check("wrap_second", obs_gnt, 4'b0001);

    // All four read 0x10 from reset: grants 0,1,2,3,0; returns follow
    step(1, 4'h0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      step(0, (i < 5) ? 4'hF : 4'h0, 4'h0, 32'h1010_1010, 32'h0);
      if (i < 5) check("rr_gnt", obs_gnt, 1 << (i % 4));
      if (i >= 2) check("rr_rvalid", obs_rvalid, 1 << ((i - 2) % 4));
    end
    check("rr_rdata", obs_rdata, 8'hA5);

    // Read granted to requester 1, then reset: no return, rdata cleared
    step(0, 4'b0010, 4'b0000, 32'h0000_1000, 32'h0);
    check("rstrd_gnt", obs_gnt, 4'b0010);
    step(1, 4'h0, 4'h0, 32'h0, 32'h0);
    step(0, 4'h0, 4'h0, 32'h0, 32'h0);
    check("rstrd_rvalid0", obs_rvalid, 0);
    check("rstrd_rdata", obs_rdata, 0);
    step(0, 4'h0, 4'h0, 32'h0, 32'h0);
    check("rstrd_rvalid1", obs_rvalid, 0);

    // Table: writes only, arbitration order from ptr = 0
    vecs[0] = '{4'b1111, 4'b0001, 2'd0};
    vecs[1] = '{4'b1110, 4'b0010, 2'd1};
    vecs[2] = '{4'b1100, 4'b0100, 2'd2};
    vecs[3] = '{4'b1001, 4'b1000, 2'd3};
    vecs[4] = '{4'b0001, 4'b0001, 2'd0};
    vecs[5] = '{4'b0000, 4'b0000, 2'd0};
    vecs[6] = '{4'b0101, 4'b0100, 2'd2};
    vecs[7] = '{4'b0000, 4'b0000, 2'd2};
    vecs[8] = '{4'b0011, 4'b0001, 2'd0};
    vecs[9] = '{4'b0011, 4'b0010, 2'd1};
    step(1, 4'h0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(0, vecs[i].req, 4'hF, $urandom, $urandom);
      check("tbl_gnt", obs_gnt, vecs[i].exp_gnt);
      check("tbl_sel", obs_sel, vecs[i].exp_sel);
    end

    // Randomized traffic; requests held until granted
    for (int k = 0; k < 4; k++) p_v[k] = 0;
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!p_v[k] && ($urandom_range(0, 1) == 1)) begin
          p_v[k] = 1;
          p_we[k] = ($urandom_range(0, 2) == 0);
          p_addr[k] = 8'($urandom_range(0, 15));
          p_data[k] = 8'($urandom);
        end
        rq[k] = p_v[k];
        wq[k] = p_we[k];
        a[k*8 +: 8] = p_addr[k];
        d[k*8 +: 8] = p_data[k];
      end
      step(($urandom_range(0, 63) == 0), rq, wq, a, d);
      for (int k = 0; k < 4; k++) if (obs_gnt[k]) p_v[k] = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
